// File: rtl/nes_video_pkg.sv
// Shared NES video constants and the 5:5:5 pixel type used by the scan
// converter and the debug overlays.
package nes_video_pkg;

   localparam int NES_VISIBLE_W  = 256;
   localparam int NES_VISIBLE_H  = 240;
   localparam int NES_LINE_DOTS  = 341;

   typedef struct packed {
      logic [4:0] b;
      logic [4:0] g;
      logic [4:0] r;
   } rgb15_t;

endpackage

// File: rtl/nes_palette_rom.sv
// Combinational NES colour index to 15-bit {B,G,R} lookup; entries are the
// 8-bit-per-channel reference palette truncated to 5 bits per channel.
module nes_palette_rom
   import nes_video_pkg::*;
(
   input  logic [5:0] index_i,
   output rgb15_t     rgb_o
);

   always_comb begin
      rgb_o = '0;
      case (index_i)
         6'h00: rgb_o = {5'd10, 5'd10, 5'd10};
         6'h01: rgb_o = {5'd14, 5'd3,  5'd0 };
         6'h02: rgb_o = {5'd18, 5'd2,  5'd1 };
         6'h03: rgb_o = {5'd17, 5'd0,  5'd6 };
         6'h04: rgb_o = {5'd12, 5'd0,  5'd8 };
         6'h05: rgb_o = {5'd6,  5'd0,  5'd11};
         6'h06: rgb_o = {5'd0,  5'd0,  5'd10};
         6'h07: rgb_o = {5'd0,  5'd3,  5'd7 };
         6'h08: rgb_o = {5'd0,  5'd5,  5'd4 };
         6'h09: rgb_o = {5'd0,  5'd7,  5'd1 };
         6'h0A: rgb_o = {5'd0,  5'd8,  5'd0 };
         6'h0B: rgb_o = {5'd0,  5'd7,  5'd0 };
         6'h0C: rgb_o = {5'd7,  5'd6,  5'd0 };
         6'h10: rgb_o = {5'd19, 5'd18, 5'd19};
         6'h11: rgb_o = {5'd24, 5'd9,  5'd1 };
         6'h12: rgb_o = {5'd29, 5'd6,  5'd6 };
         6'h13: rgb_o = {5'd28, 5'd3,  5'd11};
         6'h14: rgb_o = {5'd22, 5'd2,  5'd17};
         6'h15: rgb_o = {5'd12, 5'd2,  5'd20};
         6'h16: rgb_o = {5'd4,  5'd4,  5'd19};
         6'h17: rgb_o = {5'd0,  5'd7,  5'd15};
         6'h18: rgb_o = {5'd0,  5'd11, 5'd10};
         6'h19: rgb_o = {5'd0,  5'd14, 5'd5 };
         6'h1A: rgb_o = {5'd0,  5'd15, 5'd1 };
         6'h1B: rgb_o = {5'd5,  5'd14, 5'd0 };
         6'h1C: rgb_o = {5'd15, 5'd12, 5'd0 };
         6'h20: rgb_o = {5'd29, 5'd29, 5'd29};
         6'h21: rgb_o = {5'd29, 5'd19, 5'd9 };
         6'h22: rgb_o = {5'd29, 5'd15, 5'd15};
         6'h23: rgb_o = {5'd29, 5'd12, 5'd22};
         6'h24: rgb_o = {5'd29, 5'd10, 5'd28};
         6'h25: rgb_o = {5'd22, 5'd11, 5'd29};
         6'h26: rgb_o = {5'd12, 5'd13, 5'd29};
         6'h27: rgb_o = {5'd4,  5'd17, 5'd26};
         6'h28: rgb_o = {5'd0,  5'd21, 5'd20};
         6'h29: rgb_o = {5'd0,  5'd24, 5'd14};
         6'h2A: rgb_o = {5'd4,  5'd26, 5'd9 };
         6'h2B: rgb_o = {5'd13, 5'd25, 5'd7 };
         6'h2C: rgb_o = {5'd25, 5'd22, 5'd7 };
         6'h2D: rgb_o = {5'd7,  5'd7,  5'd7 };
         6'h30: rgb_o = {5'd29, 5'd29, 5'd29};
         6'h31: rgb_o = {5'd29, 5'd25, 5'd21};
         6'h32: rgb_o = {5'd29, 5'd23, 5'd23};
         6'h33: rgb_o = {5'd29, 5'd22, 5'd26};
         6'h34: rgb_o = {5'd29, 5'd21, 5'd29};
         6'h35: rgb_o = {5'd26, 5'd21, 5'd29};
         6'h36: rgb_o = {5'd22, 5'd22, 5'd29};
         6'h37: rgb_o = {5'd18, 5'd24, 5'd28};
         6'h38: rgb_o = {5'd15, 5'd26, 5'd25};
         6'h39: rgb_o = {5'd15, 5'd27, 5'd22};
         6'h3A: rgb_o = {5'd18, 5'd28, 5'd21};
         6'h3B: rgb_o = {5'd22, 5'd28, 5'd19};
         6'h3C: rgb_o = {5'd28, 5'd26, 5'd20};
         6'h3D: rgb_o = {5'd20, 5'd20, 5'd20};
         default: rgb_o = '0;
      endcase
   end

endmodule

// File: rtl/nes_scan_doubler.sv
// Two-line ping-pong buffer: captures the current PPU scanline while replaying
// the previous one at 2x horizontal rate, plus the frame-start sync pulse.
module nes_scan_doubler
   import nes_video_pkg::*;
#(
   parameter int VISIBLE_LINES = NES_VISIBLE_H,
   parameter int LINE_DOTS     = NES_LINE_DOTS
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        ppu_ce,
   input  logic [8:0]  ppu_x,
   input  logic [8:0]  ppu_y,
   input  logic [5:0]  ppu_color,
   input  logic        sync_en,
   input  logic [9:0]  vga_next_x,
   output logic [14:0] vga_pixel,
   output logic        vga_sync
);

   localparam logic [8:0] VIS_W     = 9'(NES_VISIBLE_W);
   localparam logic [8:0] VIS_LINES = 9'(VISIBLE_LINES);
   localparam logic [8:0] LAST_DOT  = 9'(LINE_DOTS - 1);

   logic [5:0] line_mem [0:511];

   logic       wr_en;
   logic [8:0] wr_addr;
   logic [8:0] rd_addr;
   logic       vga_line_start;

   logic       wr_bank_q, wr_bank_d;
   logic       rd_bank_q, rd_bank_d;
   logic       rd_valid_q, rd_valid_d;
   logic       line_done_valid_q, line_done_valid_d;
   logic       sync_q, sync_d;
   logic [5:0] index_q;
   rgb15_t     pal_rgb;
   logic       unused_next_x_msb;

   assign unused_next_x_msb = vga_next_x[9];

   always_comb begin
      wr_en             = ppu_ce && (ppu_x < VIS_W) && (ppu_y < VIS_LINES);
      wr_addr           = {ppu_y[0], ppu_x[7:0]};
      wr_bank_d         = ppu_ce ? ppu_y[0] : wr_bank_q;
      line_done_valid_d = line_done_valid_q;
      if (ppu_ce && (ppu_x == LAST_DOT)) begin
         line_done_valid_d = (ppu_y < VIS_LINES);
      end

      // Bank and validity only change at VGA line start, never mid-line.
      vga_line_start = (vga_next_x[8:0] == 9'd0);
      rd_bank_d      = vga_line_start ? ~wr_bank_q : rd_bank_q;
      rd_valid_d     = vga_line_start ? line_done_valid_q : rd_valid_q;
      // The address uses the incoming bank so pixel 0 already reads the new line.
      rd_addr        = {rd_bank_d, vga_next_x[8:1]};

      sync_d = ppu_ce && (ppu_x == 9'd0) && (ppu_y == 9'd0) && sync_en;
   end

   always_ff @(posedge clk) begin
      if (wr_en) begin
         line_mem[wr_addr] <= ppu_color;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         wr_bank_q         <= 1'b0;
         rd_bank_q         <= 1'b0;
         rd_valid_q        <= 1'b0;
         line_done_valid_q <= 1'b0;
         sync_q            <= 1'b0;
         index_q           <= '0;
      end else begin
         wr_bank_q         <= wr_bank_d;
         rd_bank_q         <= rd_bank_d;
         rd_valid_q        <= rd_valid_d;
         line_done_valid_q <= line_done_valid_d;
         sync_q            <= sync_d;
         index_q           <= line_mem[rd_addr];
      end
   end

   nes_palette_rom u_palette (
      .index_i (index_q),
      .rgb_o   (pal_rgb)
   );

   assign vga_pixel = rd_valid_q ? pal_rgb : 15'd0;
   assign vga_sync  = sync_q;

endmodule

// File: tb/tb_nes_scan_doubler.sv
// Directed bench for nes_scan_doubler: a cycle-stepped PPU/VGA driver with a
// scoreboard of expected {sync, pixel} values checked one cycle later.
module tb_nes_scan_doubler;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        ppu_ce;
   logic [8:0]  ppu_x;
   logic [8:0]  ppu_y;
   logic [5:0]  ppu_color;
   logic        sync_en;
   logic [9:0]  vga_next_x;
   logic [14:0] vga_pixel;
   logic        vga_sync;

   always #5 clk = ~clk;

   nes_scan_doubler dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .ppu_ce     (ppu_ce),
      .ppu_x      (ppu_x),
      .ppu_y      (ppu_y),
      .ppu_color  (ppu_color),
      .sync_en    (sync_en),
      .vga_next_x (vga_next_x),
      .vga_pixel  (vga_pixel),
      .vga_sync   (vga_sync)
   );

   // Reference NES palette, 0xRRGGBB.
   logic [23:0] pal888 [0:63] = '{
      24'h545454, 24'h001E74, 24'h081090, 24'h300088, 24'h440064, 24'h5C0030, 24'h540400, 24'h3C1800,
      24'h202A00, 24'h083A00, 24'h004000, 24'h003C00, 24'h00323C, 24'h000000, 24'h000000, 24'h000000,
      24'h989698, 24'h084CC4, 24'h3032EC, 24'h5C1EE4, 24'h8814B0, 24'hA01464, 24'h982220, 24'h783C00,
      24'h545A00, 24'h287200, 24'h087C00, 24'h007628, 24'h006678, 24'h000000, 24'h000000, 24'h000000,
      24'hECEEEC, 24'h4C9AEC, 24'h787CEC, 24'hB062EC, 24'hE454EC, 24'hEC58B4, 24'hEC6A64, 24'hD48820,
      24'hA0AA00, 24'h74C400, 24'h4CD020, 24'h38CC6C, 24'h38B4CC, 24'h3C3C3C, 24'h000000, 24'h000000,
      24'hECEEEC, 24'hA8CCEC, 24'hBCBCEC, 24'hD4B2EC, 24'hECAEEC, 24'hECAED4, 24'hECB4B0, 24'hE4C490,
      24'hCCD278, 24'hB4DE78, 24'hA8E290, 24'h98E2B4, 24'hA0D6E4, 24'hA0A2A0, 24'h000000, 24'h000000
   };

   int errors = 0;
   int checks = 0;
   int sync_seen = 0;
   logic [16:0] exp_q[$];

   int px, py, ph, vx, col_mode;
   bit ppu_run;

   function automatic logic [14:0] pal(input int idx);
      logic [23:0] p;
      p = pal888[idx & 63];
      return {p[7:3], p[15:11], p[23:19]};
   endfunction

   function automatic logic [5:0] color_of(input int mode, input int x);
      case (mode)
         0:       return 6'(x & 63);
         1:       return 6'(63 - (x & 63));
         default: return 6'h0F;
      endcase
   endfunction

   // emode 0/1: line written with colour mode 0/1; 2: 0x0F line; 3: black.
   function automatic logic [14:0] exp_pix(input int emode, input int c);
      case (emode)
         0:       return pal(c & 63);
         1:       return pal(63 - (c & 63));
         2:       return pal(15);
         default: return 15'd0;
      endcase
   endfunction

   task automatic check_out();
      logic [16:0] e;
      if (exp_q.size() == 0) return;
      e = exp_q.pop_front();
      checks++;
      assert (vga_sync === e[15]) else begin
         errors++;
         $error("FAIL sync t=%0t got=%0b exp=%0b", $time, vga_sync, e[15]);
      end
      if (vga_sync === 1'b1) sync_seen++;
      if (e[16]) begin
         checks++;
         assert (vga_pixel === e[14:0]) else begin
            errors++;
            $error("FAIL pixel t=%0t y=%0d got=%h exp=%h", $time, py, vga_pixel, e[14:0]);
         end
      end
   endtask

   task automatic step(input bit chk, input logic [14:0] pix);
      logic ce;
      ce         = ppu_run && (ph == 3);
      ppu_ce     = ce;
      ppu_x      = 9'(px);
      ppu_y      = 9'(py);
      ppu_color  = color_of(col_mode, px);
      vga_next_x = 10'(vx);
      exp_q.push_back({chk, (reset_n && ce && px == 0 && py == 0 && sync_en), pix});
      if (ppu_run) begin
         ph = (ph + 1) % 4;
         if (ce) begin
            px++;
            if (px == 341) begin
               px = 0;
               py = (py + 1) % 262;
            end
         end
      end
      @(negedge clk);
      check_out();
   endtask

   task automatic idle(input int n, input bit chk);
      vx = 1023;
      for (int i = 0; i < n; i++) step(chk, 15'd0);
   endtask

   task automatic sweep_range(input int emode, input int min_c, input int from, input int to);
      for (int k = from; k <= to; k++) begin
         vx = k;
         step((k >> 1) >= min_c, exp_pix(emode, k >> 1));
      end
      vx = 1023;
   endtask

   initial begin
      reset_n = 1'b0; sync_en = 1'b0; ppu_run = 1'b0;
      px = 0; py = 0; ph = 0; vx = 1023; col_mode = 0;
      ppu_ce = 1'b0; ppu_x = '0; ppu_y = '0; ppu_color = '0; vga_next_x = 10'd1023;
      @(negedge clk);

      // Reset state and black output before any completed line.
      idle(4, 1'b1);
      reset_n = 1'b1;
      idle(4, 1'b1);

      // Line 4: colour = x[5:0], no valid line yet so output stays black.
      py = 4; px = 0; ph = 0; ppu_run = 1'b1; col_mode = 0;
      idle(1364, 1'b1);

      // Line 5: replay line 4 doubled; line 5 written with 63-x.
      col_mode = 1;
      idle(8, 1'b0);
      sweep_range(0, 0, 0, 511);
      idle(844, 1'b0);

      // Line 6: write 0x0F, replay shows line 5; second sweep straddles line 7 start.
      col_mode = 2;
      idle(8, 1'b0);
      sweep_range(1, 0, 0, 511);
      idle(544, 1'b0);
      sweep_range(1, 0, 0, 299);
      col_mode = 1;
      sweep_range(1, 0, 300, 511);
      // Next VGA line swaps to line 6 (all 0x0F).
      sweep_range(2, 0, 0, 511);
      idle(640, 1'b0);

      // Last visible line, then lines 240/241.
      py = 239; col_mode = 0;
      idle(1364, 1'b0);
      col_mode = 2;
      idle(8, 1'b0);
      sweep_range(0, 0, 0, 511);
      idle(844, 1'b0);
      idle(8, 1'b0);
      sweep_range(3, 0, 0, 511);
      idle(844, 1'b0);

      // Frame sync enabled: exactly one pulse.
      py = 261; px = 336; sync_en = 1'b1; sync_seen = 0;
      idle(40, 1'b0);
      checks++;
      assert (sync_seen == 1) else begin
         errors++;
         $error("FAIL sync_count_en got=%0d exp=1", sync_seen);
      end

      // Frame sync disabled: no pulse.
      py = 261; px = 336; sync_en = 1'b0; sync_seen = 0;
      idle(40, 1'b0);
      checks++;
      assert (sync_seen == 0) else begin
         errors++;
         $error("FAIL sync_count_dis got=%0d exp=0", sync_seen);
      end

      // Reset mid-line during replay of line 9.
      sync_en = 1'b1;
      py = 9; px = 0; ph = 0; col_mode = 0;
      idle(1364, 1'b0);
      idle(8, 1'b0);
      sweep_range(0, 0, 0, 99);
      reset_n = 1'b0;
      sweep_range(3, 0, 100, 102);
      reset_n = 1'b1;
      sweep_range(3, 0, 103, 511);
      idle(844, 1'b1);
      // Line 10 completed after release: it becomes visible on line 11.
      idle(8, 1'b0);
      sweep_range(0, 64, 0, 511);
      idle(844, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
